// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory port and mem_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and memory responses.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    logic [1:0]    owner;
    logic          busy;
    logic          err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_done, d_rdata, d_done, m_en, m_we, m_addr, m_wdata,
               owner, busy, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_done, d_rdata, d_done, m_en, m_we, m_addr, m_wdata,
               owner, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch, data) round-robin arbiter onto a single memory port,
// with a per-access wait timeout that aborts the access and flags err alongside done.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);

    // State encoding doubles as the owner code.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        I_ACC = 2'b01,
        D_ACC = 2'b10
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t        state_q, state_d;
    logic          last_data_q, last_data_d;
    logic [7:0]    wait_q, wait_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          m_we_q, m_we_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;

    logic          elig_i, elig_d;
    logic          grant_i, grant_d;
    logic          finish, abort;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        wait_d      = wait_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_we_d      = m_we_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        elig_i      = 1'b0;
        elig_d      = 1'b0;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = 8'd0;
                // A requester still seeing its done pulse has not yet had a chance to drop req.
                elig_i  = bus.i_req && !i_done_q;
                elig_d  = bus.d_req && !d_done_q;
                grant_i = elig_i && (!elig_d || last_data_q);
                grant_d = elig_d && !grant_i;
                if (grant_i) begin
                    state_d   = I_ACC;
                    m_addr_d  = bus.i_addr;
                    m_we_d    = 1'b0;
                    m_wdata_d = '0;
                end else if (grant_d) begin
                    state_d   = D_ACC;
                    m_addr_d  = bus.d_addr;
                    m_we_d    = bus.d_we;
                    m_wdata_d = bus.d_wdata;
                end
            end

            I_ACC, D_ACC: begin
                // m_ready wins over the timeout in the last allowed cycle.
                if (bus.m_ready) begin
                    finish = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end

                if (finish) begin
                    state_d     = IDLE;
                    wait_d      = 8'd0;
                    m_we_d      = 1'b0;
                    err_d       = abort;
                    last_data_d = (state_q == D_ACC);
                    if (state_q == I_ACC) begin
                        i_done_d = 1'b1;
                        if (!abort) i_rdata_d = bus.m_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!abort && !m_we_q) d_rdata_d = bus.m_rdata;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_data_q <= 1'b1;
            wait_q      <= 8'd0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_we_q      <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
            wait_q      <= wait_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.m_en    = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.owner   = state_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_done  = i_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_WAIT=4): a vector table stepped one clock per entry,
// then a hand-written asynchronous reset in the middle of a data access.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   nchk;
    int   nerr;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] m_rdata;
        logic        m_ready;
        logic [1:0]  e_owner;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_idone;
        logic        e_ddone;
        logic        e_err;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n       = v.rst_n;
        bus.i_req   = v.i_req;
        bus.i_addr  = v.i_addr;
        bus.d_req   = v.d_req;
        bus.d_we    = v.d_we;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
        bus.m_rdata = v.m_rdata;
        bus.m_ready = v.m_ready;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        string p;
        p = $sformatf("v%0d", k);
        chk({p, ".owner"},   32'(bus.owner),   32'(v.e_owner));
        chk({p, ".m_en"},    32'(bus.m_en),    32'(v.e_owner != 2'b00));
        chk({p, ".busy"},    32'(bus.busy),    32'(v.e_owner != 2'b00));
        chk({p, ".m_we"},    32'(bus.m_we),    32'(v.e_we));
        chk({p, ".m_addr"},  bus.m_addr,       v.e_addr);
        chk({p, ".m_wdata"}, bus.m_wdata,      v.e_wdata);
        chk({p, ".i_done"},  32'(bus.i_done),  32'(v.e_idone));
        chk({p, ".d_done"},  32'(bus.d_done),  32'(v.e_ddone));
        chk({p, ".err"},     32'(bus.err),     32'(v.e_err));
        chk({p, ".i_rdata"}, bus.i_rdata,      v.e_irdata);
        chk({p, ".d_rdata"}, bus.d_rdata,      v.e_drdata);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;

        // rst ireq iaddr dreq dwe daddr dwdata mrdata mready | owner we addr wdata idone ddone err irdata drdata
        // single fetch, then m_ready ignored in IDLE
        vq.push_back('{1,1,32'h40,0,0,0,0,0,0,                      1,0,32'h40,0,0,0,0,0,0});
        vq.push_back('{1,1,32'h40,0,0,0,0,32'h12345678,1,           0,0,32'h40,0,1,0,0,32'h12345678,0});
        vq.push_back('{1,0,0,0,0,0,0,32'hDEADBEEF,1,                0,0,32'h40,0,0,0,0,32'h12345678,0});
        // reset clears everything, last owner back to data
        vq.push_back('{0,0,0,0,0,0,0,0,0,                           0,0,0,0,0,0,0,0,0});
        // tie from reset: fetch, data, fetch
        vq.push_back('{1,1,32'h200,1,0,32'h300,0,0,0,               1,0,32'h200,0,0,0,0,0,0});
        vq.push_back('{1,1,32'h200,1,0,32'h300,0,32'h11111111,1,    0,0,32'h200,0,1,0,0,32'h11111111,0});
        vq.push_back('{1,1,32'h200,1,0,32'h300,0,0,0,               2,0,32'h300,0,0,0,0,32'h11111111,0});
        vq.push_back('{1,1,32'h200,1,0,32'h300,0,32'h22222222,1,    0,0,32'h300,0,0,1,0,32'h11111111,32'h22222222});
        vq.push_back('{1,1,32'h200,1,0,32'h300,0,0,0,               1,0,32'h200,0,0,0,0,32'h11111111,32'h22222222});
        vq.push_back('{1,1,32'h200,0,0,0,0,32'h33333333,1,          0,0,32'h200,0,1,0,0,32'h33333333,32'h22222222});
        // fetch req still high during its done cycle: no grant
        vq.push_back('{1,1,32'h200,0,0,0,0,0,0,                     0,0,32'h200,0,0,0,0,32'h33333333,32'h22222222});
        vq.push_back('{1,1,32'h204,0,0,0,0,0,0,                     1,0,32'h204,0,0,0,0,32'h33333333,32'h22222222});
        vq.push_back('{1,1,32'h204,0,0,0,0,32'h44444444,1,          0,0,32'h204,0,1,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,0,0,0,0,0,0,                           0,0,32'h204,0,0,0,0,32'h44444444,32'h22222222});
        // write with 3 wait cycles; inputs change mid-access and req drops before ready
        vq.push_back('{1,0,0,1,1,32'h100,32'hCAFEF00D,0,0,          2,1,32'h100,32'hCAFEF00D,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h999,0,0,0,                     2,1,32'h100,32'hCAFEF00D,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h999,0,0,0,                     2,1,32'h100,32'hCAFEF00D,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h999,0,0,0,                     2,1,32'h100,32'hCAFEF00D,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,0,0,0,0,32'h55555555,1,                0,0,32'h100,32'hCAFEF00D,0,1,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,0,0,0,0,0,0,                           0,0,32'h100,32'hCAFEF00D,0,0,0,32'h44444444,32'h22222222});
        // timeout: 4 wait cycles then abort with err, rdata untouched
        vq.push_back('{1,0,0,1,0,32'h500,0,0,0,                     2,0,32'h500,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h500,0,0,0,                     2,0,32'h500,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h500,0,0,0,                     2,0,32'h500,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h500,0,0,0,                     2,0,32'h500,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,1,0,32'h500,0,32'h77777777,0,          0,0,32'h500,0,0,1,1,32'h44444444,32'h22222222});
        vq.push_back('{1,0,0,0,0,0,0,0,0,                           0,0,32'h500,0,0,0,0,32'h44444444,32'h22222222});
        // m_ready in the last allowed cycle completes normally
        vq.push_back('{1,1,32'h600,0,0,0,0,0,0,                     1,0,32'h600,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,1,32'h600,0,0,0,0,0,0,                     1,0,32'h600,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,1,32'h600,0,0,0,0,0,0,                     1,0,32'h600,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,1,32'h600,0,0,0,0,0,0,                     1,0,32'h600,0,0,0,0,32'h44444444,32'h22222222});
        vq.push_back('{1,1,32'h600,0,0,0,0,32'h66666666,1,          0,0,32'h600,0,1,0,0,32'h66666666,32'h22222222});
        vq.push_back('{1,0,0,0,0,0,0,0,0,                           0,0,32'h600,0,0,0,0,32'h66666666,32'h22222222});

        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_ready = 1'b0;

        @(negedge clk);
        chk("rst.owner",   32'(bus.owner),  32'h0);
        chk("rst.m_en",    32'(bus.m_en),   32'h0);
        chk("rst.busy",    32'(bus.busy),   32'h0);
        chk("rst.m_addr",  bus.m_addr,      32'h0);
        chk("rst.i_done",  32'(bus.i_done), 32'h0);
        chk("rst.err",     32'(bus.err),    32'h0);

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k]);
            @(posedge clk);
            @(negedge clk);
            check_vec(k, vq[k]);
        end

        // reset in the middle of a data write
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h700;
        bus.d_wdata = 32'hAAAA5555;
        bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid.owner_before", 32'(bus.owner), 32'h2);
        chk("mid.m_we_before",  32'(bus.m_we),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.owner",   32'(bus.owner),  32'h0);
        chk("mid.m_en",    32'(bus.m_en),   32'h0);
        chk("mid.busy",    32'(bus.busy),   32'h0);
        chk("mid.m_we",    32'(bus.m_we),   32'h0);
        chk("mid.m_addr",  bus.m_addr,      32'h0);
        chk("mid.m_wdata", bus.m_wdata,     32'h0);
        chk("mid.d_done",  32'(bus.d_done), 32'h0);
        chk("mid.err",     32'(bus.err),    32'h0);
        chk("mid.i_rdata", bus.i_rdata,     32'h0);
        chk("mid.d_rdata", bus.d_rdata,     32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid.d_done_held", 32'(bus.d_done), 32'h0);
        rst_n       = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h800;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h900;
        @(posedge clk);
        @(negedge clk);
        chk("post.owner",  32'(bus.owner),  32'h1);
        chk("post.m_addr", bus.m_addr,      32'h800);
        chk("post.d_done", 32'(bus.d_done), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter AW, default 32, address width.
REQ-002 SHALL provide parameter DW, default 32, data width.
REQ-003 SHALL provide parameter MAX_WAIT, default 15, maximum wait cycles before an access is aborted (range 1..255).
REQ-004 CLK  in  1  clock; all state changes on the rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  instruction-fetch read request; level, held until i_done.
REQ-007 i_addr  in  AW  fetch address.
REQ-008 i_rdata  out  DW  fetched word.
REQ-009 i_done  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data request; level, held until d_done.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  AW  data address.
REQ-013 d_wdata  in  DW  write data.
REQ-014 d_rdata  out  DW  read data.
REQ-015 d_done  out  1  one-cycle data completion pulse.
REQ-016 m_en, m_we  out  1 each  memory access enable and write strobe.
REQ-017 m_addr, m_wdata  out  AW, DW  memory address and write data.
REQ-018 m_rdata  in  DW  memory read data; m_ready  in  1  access complete.
REQ-019 owner  out  2  current grant: 00 none, 01 fetch, 10 data.
REQ-020 busy, err  out  1 each  access in progress; one-cycle timeout pulse.

Function
REQ-021 SHALL implement FSM states IDLE, I_ACC, D_ACC; busy = (state != IDLE); owner = 01 in I_ACC, 10 in D_ACC, 00 in IDLE.
REQ-022 IDLE arbitration: a single eligible request SHALL be granted; with both eligible, the requester not served last SHALL be granted (round-robin on a last_owner register).
REQ-023 A requester whose done is high in the current cycle SHALL be ineligible for arbitration in that cycle.
REQ-024 On a grant, m_addr, m_we and m_wdata SHALL be registered from the winner at the grant edge and held stable for the whole access; m_we SHALL be 0 for fetches.
REQ-025 m_en SHALL be 1 exactly while in I_ACC or D_ACC.
REQ-026 Latency: a request sampled in IDLE at edge N SHALL give m_en=1 in cycle N+1; m_ready=1 in that cycle SHALL give done=1 in cycle N+2, in IDLE.
REQ-027 m_ready SHALL be ignored in IDLE.
REQ-028 On read completion (m_ready=1), m_rdata SHALL be captured into i_rdata or d_rdata, valid from the done cycle and held until the next read by that requester.
REQ-029 A write completion SHALL NOT change d_rdata.
REQ-030 Every completion SHALL return the FSM to IDLE and update last_owner; back-to-back accesses are therefore separated by one IDLE cycle.
REQ-031 A wait counter SHALL count access cycles with m_ready=0.
REQ-032 When the wait counter reaches MAX_WAIT, the access SHALL abort: return to IDLE, pulse done together with err for one cycle, and leave rdata unchanged.
REQ-033 m_ready=1 in the same cycle the counter reaches MAX_WAIT SHALL count as a normal completion with err=0.
REQ-034 d_we, d_wdata and the address inputs SHALL be ignored except at the grant edge.
REQ-035 Dropping a req mid-access SHALL NOT abort the access; its done SHALL still be issued.

Reset
REQ-036 RST=0 SHALL immediately force state IDLE; m_en, m_we, done, err and owner to 0; m_addr, m_wdata, i_rdata and d_rdata to 0; wait counter to 0; last_owner to data (fetch wins the first tie).
REQ-037 Reset during an access SHALL discard it with no done pulse.

Verification
REQ-038 Single fetch: i_req=1, addr 0x40, m_ready high in the first access cycle, m_rdata 0x12345678 -> m_en for 1 cycle, i_done at cycle 2, i_rdata=0x12345678.
REQ-039 Tie: both requests from reset -> fetch first, data next after one IDLE cycle, fetch again if re-requested; owner sequence 01,00,10,00,01.
REQ-040 Write: d_we=1, addr 0x100, wdata 0xCAFEF00D, m_ready after 3 wait cycles -> m_we=1 and m_addr stable for 4 cycles, d_done pulse, d_rdata unchanged.
REQ-041 Timeout: MAX_WAIT=4, m_ready never asserted -> abort after 4 wait cycles, d_done=err=1 for one cycle, busy=0 next cycle.
REQ-042 Reset mid-access: RST low during D_ACC -> all outputs 0 asynchronously, no d_done; next tie after reset goes to fetch.
